// File: rtl/sub_b_deser.sv
// Serial-to-parallel capture stage: assembles MSB-first words from sub_a's
// framed bit stream and queues them in a show-ahead FIFO for top.
module sub_b_deser #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sub_a__sub_b__s1,
    input  logic                     ssub_b__sub_b__s1,
    input  logic                     top__sub_b__ready,
    input  logic                     top__sub_b__clr,
    output logic [DW-1:0]            sub_b__top__data,
    output logic                     sub_b__top__valid,
    output logic [$clog2(DEPTH):0]   sub_b__top__level,
    output logic                     sub_b__top__ovf,
    output logic                     sub_b__top__frm_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DW);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   bit_cnt, bit_cnt_nx;
    // Only the low DW-1 bits are ever shifted up into a word, so the MSB is not stored.
    logic [DW-2:0]   shreg, shreg_nx;
    logic [DW-1:0]   push_word;
    logic            push, frm_set;

    logic [DW-1:0]   mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr, level;
    logic            valid, full, pop, wr_en, ovf_set;
    logic            ovf, frm_err;

    assign push_word = {shreg, sub_a__sub_b__s1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            shreg   <= shreg_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        push       = 1'b0;
        frm_set    = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_nx = '0;
                if (ssub_b__sub_b__s1) begin
                    shreg_nx   = push_word[DW-2:0];
                    bit_cnt_nx = CW'(1);
                    state_nx   = SHIFT;
                end
            end
            SHIFT: begin
                if (ssub_b__sub_b__s1) begin
                    shreg_nx = push_word[DW-2:0];
                    if (bit_cnt == CW'(DW - 1)) begin
                        push       = 1'b1;
                        bit_cnt_nx = '0;
                    end else begin
                        bit_cnt_nx = bit_cnt + 1'b1;
                    end
                end else begin
                    frm_set    = (bit_cnt != '0);
                    bit_cnt_nx = '0;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign level   = wr_ptr - rd_ptr;
    assign valid   = (level != '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign pop     = valid & top__sub_b__ready;
    assign wr_en   = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= push_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovf     <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (ovf_set)
                ovf <= 1'b1;
            else if (top__sub_b__clr)
                ovf <= 1'b0;
            if (frm_set)
                frm_err <= 1'b1;
            else if (top__sub_b__clr)
                frm_err <= 1'b0;
        end
    end

    assign sub_b__top__data    = valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign sub_b__top__valid   = valid;
    assign sub_b__top__level   = level;
    assign sub_b__top__ovf     = ovf;
    assign sub_b__top__frm_err = frm_err;

endmodule

// File: tb/tb_sub_b_deser.sv
// Bench for sub_b_deser: directed scenarios plus random traffic, compared
// every cycle against a queue-based model of the deserializer and FIFO.
module tb_sub_b_deser;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sbit = 1'b0;
    logic       en = 1'b0;
    logic       rdy = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [2:0] level;
    logic       ovf;
    logic       frm_err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int unsigned m_n = 0;
    logic [7:0]  m_acc = '0;
    logic [7:0]  m_q[$];
    logic        m_ovf = 1'b0;
    logic        m_frm = 1'b0;

    sub_b_deser #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .sub_a__sub_b__s1    (sbit),
        .ssub_b__sub_b__s1   (en),
        .top__sub_b__ready   (rdy),
        .top__sub_b__clr     (clr),
        .sub_b__top__data    (data),
        .sub_b__top__valid   (valid),
        .sub_b__top__level   (level),
        .sub_b__top__ovf     (ovf),
        .sub_b__top__frm_err (frm_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("valid", 32'(valid), 32'(m_q.size() != 0));
        chk("level", 32'(level), 32'(m_q.size()));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("frm_err", 32'(frm_err), 32'(m_frm));
        if (m_q.size() != 0)
            chk("data", 32'(data), 32'(m_q[0]));
    endtask

    task automatic model_step(input logic e, input logic b, input logic r, input logic c);
        logic       pop, push, oset, fset;
        logic [7:0] w;
        pop  = (m_q.size() != 0) && r;
        push = 1'b0;
        oset = 1'b0;
        fset = 1'b0;
        w    = '0;
        if (e) begin
            m_acc = {m_acc[6:0], b};
            m_n++;
            if (m_n == DW) begin
                push = 1'b1;
                w    = m_acc;
                m_n  = 0;
            end
        end else begin
            fset = (m_n != 0);
            m_n  = 0;
        end
        if (pop)
            void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH)
                m_q.push_back(w);
            else
                oset = 1'b1;
        end
        m_ovf = oset ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_frm = fset ? 1'b1 : (c ? 1'b0 : m_frm);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic e, input logic b, input logic r, input logic c);
        en = e; sbit = b; rdy = r; clr = c;
        @(posedge clk);
        model_step(e, b, r, c);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic r_body, input logic r_last,
                             input logic c_last);
        for (int i = 7; i >= 1; i--)
            cycle(1'b1, v[i], r_body, 1'b0);
        cycle(1'b1, v[0], r_last, c_last);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++)
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Asserts reset away from any clock edge and checks outputs clear at once.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        en = 1'b0; rdy = 1'b0; clr = 1'b0; sbit = 1'b0;
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_frm", 32'(frm_err), 32'd0);
        m_q.delete();
        m_n = 0;
        m_acc = '0;
        m_ovf = 1'b0;
        m_frm = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Single byte with ready high: delivered and popped next cycle
        send_byte(8'hA5, 1'b1, 1'b1, 1'b0);
        chk("a5_valid", 32'(valid), 32'd1);
        chk("a5_data", 32'(data), 32'hA5);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("a5_level", 32'(level), 32'd0);

        // Four back-to-back bytes into a stalled consumer, then drain in order
        for (int i = 1; i <= 4; i++)
            send_byte(8'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_level", 32'(level), 32'd4);
        chk("fill_ovf", 32'(ovf), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", 32'(data), 32'(i));
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("drain_valid", 32'(valid), 32'd0);

        // Overflow drop, then full push with simultaneous pop
        for (int i = 1; i <= 4; i++)
            send_byte(8'(i), 1'b0, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_head", 32'(data), 32'h01);
        send_byte(8'h55, 1'b0, 1'b1, 1'b0);
        chk("fullpop_level", 32'(level), 32'd4);
        chk("fullpop_head", 32'(data), 32'h02);
        drain();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(ovf), 32'd0);

        // Framing error on a 5-bit partial word
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'(i), 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("frm_set", 32'(frm_err), 32'd1);
        chk("frm_nopush", 32'(level), 32'd0);
        send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
        chk("frm_next", 32'(data), 32'h3C);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("frm_clr", 32'(frm_err), 32'd0);

        // Reset mid-word with two words queued
        send_byte(8'h11, 1'b0, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        send_byte(8'h81, 1'b0, 1'b0, 1'b0);
        chk("post_rst_level", 32'(level), 32'd1);
        chk("post_rst_data", 32'(data), 32'h81);
        drain();

        // Clear coincident with an overflow drop: set wins
        for (int i = 0; i < 4; i++)
            send_byte(8'($urandom), 1'b0, 1'b0, 1'b0);
        send_byte(8'h77, 1'b0, 1'b0, 1'b1);
        chk("clr_vs_ovf", 32'(ovf), 32'd1);
        drain();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0)
                do_reset();
            else
                cycle(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 31) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
